// File: rtl/cordic_iter_engine_if.sv
// cordic_iter_engine_if: operand, index-stream and result signals of the CORDIC iteration engine
interface cordic_iter_engine_if #(parameter int WIDTH = 16);
  logic [1:0] coordinate_system_in;
  logic mode_in;
  logic start;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic [5:0] idx_in;
  logic idx_valid;
  logic idx_last;
  logic idx_ready;
  logic busy;
  logic done;
  logic err;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;
  modport master (
    output coordinate_system_in, mode_in, start, x_in, y_in, z_in, idx_in, idx_valid, idx_last,
    input idx_ready, busy, done, err, x_out, y_out, z_out
  );
  modport slave (
    input coordinate_system_in, mode_in, start, x_in, y_in, z_in, idx_in, idx_valid, idx_last,
    output idx_ready, busy, done, err, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: one CORDIC micro-rotation per index accepted from counter_mod
module cordic_iter_engine #(
  parameter int WIDTH = 16,
  parameter int FRAC = 13,
  parameter int ROM_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  cordic_iter_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [1:0] LIN = 2'b00;
  localparam logic [1:0] HYP = 2'b11;
  localparam logic [1:0] RSV = 2'b10;
  // round(atan(2^-i) * 2^13) and round(atanh(2^-i) * 2^13); atanh entry 0 is never used
  localparam logic signed [15:0] ATAN [16] = '{
    16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128, 16'sd64,
    16'sd32, 16'sd16, 16'sd8, 16'sd4, 16'sd2, 16'sd1, 16'sd0, 16'sd0
  };
  localparam logic signed [15:0] ATANH [16] = '{
    16'sd0, 16'sd4500, 16'sd2092, 16'sd1029, 16'sd513, 16'sd256, 16'sd128, 16'sd64,
    16'sd32, 16'sd16, 16'sd8, 16'sd4, 16'sd2, 16'sd1, 16'sd1, 16'sd0
  };
  state_t state;
  logic [1:0] cs;
  logic mode;
  logic signed [WIDTH-1:0] x, y, z, xs, ys, e, x_n, y_n, z_n;
  logic dp, hyp0, in_rom;
  // micro-rotation for the index currently offered; index 0 in hyperbolic mode is a no-op
  always_comb begin
    xs = x >>> bus.idx_in;
    ys = y >>> bus.idx_in;
    dp = mode ? y[WIDTH-1] : ~z[WIDTH-1];
    in_rom = cs != LIN && bus.idx_in < 6'(ROM_DEPTH);
    e = in_rom ? (cs == HYP ? WIDTH'(ATANH[bus.idx_in[3:0]]) : WIDTH'(ATAN[bus.idx_in[3:0]]))
      : bus.idx_in > 6'(FRAC) ? '0 : WIDTH'(1) << (6'(FRAC) - bus.idx_in);
    hyp0 = cs == HYP && bus.idx_in == 6'd0;
    x_n = (hyp0 || cs == LIN) ? x : (dp ^ (cs == HYP)) ? x - ys : x + ys;
    y_n = hyp0 ? y : dp ? y + xs : y - xs;
    z_n = hyp0 ? z : dp ? z - e : z + e;
  end
  // control FSM with registered handshake/status outputs and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cs <= '0;
      mode <= 1'b0;
      x <= '0;
      y <= '0;
      z <= '0;
      bus.idx_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.x_out <= '0;
      bus.y_out <= '0;
      bus.z_out <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          cs <= bus.coordinate_system_in;
          mode <= bus.mode_in;
          x <= bus.x_in;
          y <= bus.y_in;
          z <= bus.z_in;
          bus.err <= bus.coordinate_system_in == RSV;
          if (bus.coordinate_system_in == RSV) begin
            bus.x_out <= bus.x_in;
            bus.y_out <= bus.y_in;
            bus.z_out <= bus.z_in;
            bus.done <= 1'b1;
            state <= DONE;
          end else begin
            bus.busy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          bus.idx_ready <= 1'b1;
          state <= RUN;
        end
        RUN: if (bus.idx_valid) begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (hyp0) bus.err <= 1'b1;
          if (bus.idx_last) begin
            bus.x_out <= x_n;
            bus.y_out <= y_n;
            bus.z_out <= z_n;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            bus.idx_ready <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
